csc_block_scheduler: RTL and testbench

//  Shares one rgb2ycbcr_v2 colour-space converter between two RGB pixel sources.

---
 rtl/csc_block_scheduler.sv | 175 +++++++++++++++++
 tb/tb_csc_block_scheduler.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csc_block_scheduler.sv
// Shares one RGB->YCbCr converter between two pixel sources, granting whole
// blocks round-robin and buffering tagged results in a small output FIFO.
module csc_block_scheduler #(
    parameter int RGB_N      = 8,
    parameter int BLK_PIX    = 64,
    parameter int OBUF_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             s0_vld,
    output logic             s0_rdy,
    input  logic [RGB_N-1:0] s0_r,
    input  logic [RGB_N-1:0] s0_g,
    input  logic [RGB_N-1:0] s0_b,
    input  logic             s1_vld,
    output logic             s1_rdy,
    input  logic [RGB_N-1:0] s1_r,
    input  logic [RGB_N-1:0] s1_g,
    input  logic [RGB_N-1:0] s1_b,
    output logic             cv_vld_i,
    output logic [RGB_N-1:0] cv_r,
    output logic [RGB_N-1:0] cv_g,
    output logic [RGB_N-1:0] cv_b,
    input  logic             cv_vld_o,
    input  logic [7:0]       cv_y,
    input  logic [7:0]       cv_cb,
    input  logic [7:0]       cv_cr,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [7:0]       out_y,
    output logic [7:0]       out_cb,
    output logic [7:0]       out_cr,
    output logic             out_src,
    output logic             out_last,
    output logic             blk_done,
    output logic             err,
    output logic             fsm_state
);

    // Handshakes: a transfer happens on any edge where vld & rdy are both high;
    // rdy never depends on the same-cycle vld of that port.

    localparam int CW = (BLK_PIX > 1) ? $clog2(BLK_PIX) : 1;
    localparam int PW = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
    localparam int EW = 26;

    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

    state_t          state_q, state_d;
    logic            gnt_q, gnt_d;
    logic            rr_q;
    logic [CW-1:0]   pix_cnt_q;
    logic            inflight_q;
    logic            tag_src_q, tag_last_q;
    logic            err_q;

    logic [EW-1:0]   mem [OBUF_DEPTH];
    logic [PW-1:0]   wr_q, rd_q;
    logic [PW:0]     fifo_cnt_q;
    logic [EW-1:0]   hold_q;
    logic [EW-1:0]   head;

    logic            sel_vld;
    logic [RGB_N-1:0] sel_r, sel_g, sel_b;
    logic [PW+1:0]   credit_sum;
    logic            credit_ok;
    logic            issue, last_pix, grant;
    logic            push, pop;

    assign sel_vld = gnt_q ? s1_vld : s0_vld;
    assign sel_r   = gnt_q ? s1_r   : s0_r;
    assign sel_g   = gnt_q ? s1_g   : s0_g;
    assign sel_b   = gnt_q ? s1_b   : s0_b;

    // Credit uses only registered occupancy, so a same-cycle pop frees nothing.
    assign credit_sum = {1'b0, fifo_cnt_q} + (PW+2)'(inflight_q);
    assign credit_ok  = credit_sum < (PW+2)'(OBUF_DEPTH);

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        grant    = 1'b0;
        issue    = 1'b0;
        last_pix = 1'b0;
        s0_rdy   = 1'b0;
        s1_rdy   = 1'b0;
        case (state_q)
            IDLE: begin
                if (s0_vld && s1_vld) gnt_d = rr_q;
                else if (s1_vld)      gnt_d = 1'b1;
                else if (s0_vld)      gnt_d = 1'b0;
                if (s0_vld || s1_vld) begin
                    grant   = 1'b1;
                    state_d = BURST;
                end
            end
            BURST: begin
                s0_rdy   = !gnt_q && credit_ok;
                s1_rdy   = gnt_q && credit_ok;
                issue    = sel_vld && credit_ok;
                last_pix = issue && (pix_cnt_q == CW'(BLK_PIX - 1));
                if (last_pix) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign cv_vld_i  = issue;
    assign cv_r      = issue ? sel_r : '0;
    assign cv_g      = issue ? sel_g : '0;
    assign cv_b      = issue ? sel_b : '0;
    assign blk_done  = last_pix;
    assign fsm_state = (state_q == BURST);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            gnt_q      <= 1'b0;
            rr_q       <= 1'b0;
            pix_cnt_q  <= '0;
            inflight_q <= 1'b0;
            tag_src_q  <= 1'b0;
            tag_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            inflight_q <= issue;
            if (grant) begin
                pix_cnt_q <= '0;
            end else if (issue) begin
                pix_cnt_q  <= last_pix ? '0 : pix_cnt_q + 1'b1;
                tag_src_q  <= gnt_q;
                tag_last_q <= last_pix;
            end
            if (last_pix) rr_q <= ~gnt_q;
        end
    end

    // A converter result is only legal one cycle after an issue.
    assign push = cv_vld_o && inflight_q;
    assign pop  = out_vld && out_rdy;

    always_ff @(posedge clk) begin
        if (push) mem[wr_q] <= {tag_src_q, tag_last_q, cv_y, cv_cb, cv_cr};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_q       <= '0;
            rd_q       <= '0;
            fifo_cnt_q <= '0;
            hold_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            if (cv_vld_o && !inflight_q) err_q <= 1'b1;
            if (push) wr_q <= wr_q + 1'b1;
            if (pop) begin
                rd_q   <= rd_q + 1'b1;
                hold_q <= head;
            end
            case ({push, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + 1'b1;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - 1'b1;
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    // When empty, the outputs keep showing the most recently popped entry.
    assign head    = mem[rd_q];
    assign out_vld = (fifo_cnt_q != '0);
    assign {out_src, out_last, out_y, out_cb, out_cr} = out_vld ? head : hold_q;
    assign err     = err_q;

endmodule

// File: tb/tb_csc_block_scheduler.sv
// Directed bench for csc_block_scheduler with a behavioural 1-cycle converter
// and a queue-based scoreboard popped by an independent output monitor.
module tb_csc_block_scheduler;

    logic       clk = 1'b0;
    logic       rstn;
    logic       s0_vld, s0_rdy, s1_vld, s1_rdy;
    logic [7:0] s0_r, s0_g, s0_b, s1_r, s1_g, s1_b;
    logic       cv_vld_i, cv_vld_o;
    logic [7:0] cv_r, cv_g, cv_b, cv_y, cv_cb, cv_cr;
    logic       out_vld, out_rdy, out_src, out_last, blk_done, err, fsm_state;
    logic [7:0] out_y, out_cb, out_cr;

    csc_block_scheduler #(.RGB_N(8), .BLK_PIX(64), .OBUF_DEPTH(4)) dut (
        .clk(clk), .rstn(rstn),
        .s0_vld(s0_vld), .s0_rdy(s0_rdy), .s0_r(s0_r), .s0_g(s0_g), .s0_b(s0_b),
        .s1_vld(s1_vld), .s1_rdy(s1_rdy), .s1_r(s1_r), .s1_g(s1_g), .s1_b(s1_b),
        .cv_vld_i(cv_vld_i), .cv_r(cv_r), .cv_g(cv_g), .cv_b(cv_b),
        .cv_vld_o(cv_vld_o), .cv_y(cv_y), .cv_cb(cv_cb), .cv_cr(cv_cr),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_y(out_y), .out_cb(out_cb),
        .out_cr(out_cr), .out_src(out_src), .out_last(out_last),
        .blk_done(blk_done), .err(err), .fsm_state(fsm_state)
    );

    // Clock / cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural converter (integer BT.601), reset with the scheduler
    logic conv_vld, spur;
    logic [7:0] conv_y, conv_cb, conv_cr;

    function automatic logic [23:0] conv(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        int ri, gi, bi, y, cb, cr;
        ri = r; gi = g; bi = b;
        y  = 16  + ((66 * ri + 129 * gi + 25 * bi + 128) >>> 8);
        cb = 128 + ((-38 * ri - 74 * gi + 112 * bi + 128) >>> 8);
        cr = 128 + ((112 * ri - 94 * gi - 18 * bi + 128) >>> 8);
        return {y[7:0], cb[7:0], cr[7:0]};
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            conv_vld <= 1'b0;
            conv_y <= '0; conv_cb <= '0; conv_cr <= '0;
        end else begin
            conv_vld <= cv_vld_i;
            {conv_y, conv_cb, conv_cr} <= conv(cv_r, cv_g, cv_b);
        end
    end
    assign cv_vld_o = conv_vld | spur;
    assign cv_y = conv_y;
    assign cv_cb = conv_cb;
    assign cv_cr = conv_cr;

    // Source models
    int idx[2], lim[2];
    bit en[2], hold[2];
    bit pat;

    function automatic logic [23:0] pix(input int s, input int i);
        logic [7:0] v, r, g, b;
        if (pat) begin
            v = (i % 2 == 1) ? 8'd0 : 8'd255;
            return {v, v, v};
        end
        r = 8'(i * 3 + s * 50);
        g = 8'(i * 2 + 7);
        b = 8'(255 - i);
        return {r, g, b};
    endfunction

    function automatic logic [23:0] exp_ycc(input int s, input int i);
        logic [23:0] p;
        if (pat) return (i % 2 == 1) ? {8'd16, 8'd128, 8'd128} : {8'd235, 8'd128, 8'd128};
        p = pix(s, i);
        return conv(p[23:16], p[15:8], p[7:0]);
    endfunction

    initial begin
        forever begin
            @(negedge clk); #1;
            s0_vld = en[0] && (idx[0] < lim[0]) && !hold[0];
            s1_vld = en[1] && (idx[1] < lim[1]) && !hold[1];
            {s0_r, s0_g, s0_b} = pix(0, idx[0]);
            {s1_r, s1_g, s1_b} = pix(1, idx[1]);
        end
    end

    // Scoreboard
    logic [25:0] exp_q[$];
    int blk_src_q[$], blk_start_q[$], blk_end_q[$];
    int errors = 0, checks = 0;
    int first_acc, first_out, out_cnt, last_cnt, done_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Accept logger: pushes the expected converted pixel on each handshake
    initial begin
        forever begin
            @(negedge clk); #4;
            if (rstn) begin
                for (int s = 0; s < 2; s++) begin
                    if ((s == 0) ? (s0_vld && s0_rdy) : (s1_vld && s1_rdy)) begin
                        exp_q.push_back({(s == 1), (idx[s] % 64 == 63), exp_ycc(s, idx[s])});
                        if (idx[s] % 64 == 0) begin
                            blk_src_q.push_back(s);
                            blk_start_q.push_back(cyc);
                        end
                        if (idx[s] % 64 == 63) blk_end_q.push_back(cyc);
                        if (first_acc < 0) first_acc = cyc;
                        idx[s]++;
                    end
                end
                if (blk_done) done_cnt++;
            end
        end
    end

    // Output monitor
    initial begin
        forever begin
            @(negedge clk); #4;
            if (rstn && out_vld && out_rdy) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected", {out_src, out_last, out_y, out_cb, out_cr}, 32'hffff_ffff);
                end else begin
                    chk("sb_data", {out_src, out_last, out_y, out_cb, out_cr}, exp_q.pop_front());
                end
                out_cnt++;
                if (out_last) last_cnt++;
                if (first_out < 0) first_out = cyc;
            end
        end
    end

    task automatic clear_stats();
        blk_src_q.delete(); blk_start_q.delete(); blk_end_q.delete();
        first_acc = -1; first_out = -1;
        out_cnt = 0; last_cnt = 0; done_cnt = 0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while ((idx[0] < lim[0] || idx[1] < lim[1] || exp_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("done_in_budget", n < budget, 1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int base0, base1, n;

    initial begin
        rstn = 1'b0; out_rdy = 1'b1; spur = 1'b0; pat = 1'b0;
        s0_vld = 0; s1_vld = 0;
        {s0_r, s0_g, s0_b, s1_r, s1_g, s1_b} = '0;
        for (int s = 0; s < 2; s++) begin idx[s] = 0; lim[s] = 0; en[s] = 0; hold[s] = 0; end
        clear_stats();

        // Reset state
        repeat (2) @(negedge clk);
        #4;
        chk("rst_ctrl", {out_vld, s0_rdy, s1_rdy, cv_vld_i, blk_done, err, fsm_state}, 0);
        chk("rst_data", {out_y, out_cb, out_cr, out_src, out_last}, 0);
        @(negedge clk); rstn = 1'b1;

        // 1: single source block
        clear_stats();
        lim[0] = idx[0] + 64; en[0] = 1;
        wait_done(400);
        chk("t1_out_cnt", out_cnt, 64);
        chk("t1_last_cnt", last_cnt, 1);
        chk("t1_blk_done", done_cnt, 1);
        chk("t1_latency", first_out - first_acc, 2);
        chk("t1_src", (blk_src_q.size() == 1) ? blk_src_q[0] : -1, 0);

        // 2: both sources continuous, alternating blocks
        clear_stats();
        lim[0] = idx[0] + 128; lim[1] = idx[1] + 128; en[1] = 1;
        wait_done(800);
        chk("t2_blocks", blk_src_q.size(), 4);
        chk("t2_blk_done", done_cnt, 4);
        if (blk_src_q.size() == 4 && blk_end_q.size() == 4) begin
            for (int k = 0; k < 3; k++) begin
                chk("t2_alternate", blk_src_q[k+1] != blk_src_q[k], 1);
                chk("t2_idle_gap", blk_start_q[k+1] - blk_end_q[k], 2);
                chk("t2_blk_len", blk_end_q[k] - blk_start_q[k], 63);
            end
        end
        en[1] = 0;

        // 3: white / black pixels
        clear_stats();
        pat = 1; lim[0] = idx[0] + 64;
        wait_done(400);
        pat = 0;
        chk("t3_out_cnt", out_cnt, 64);

        // 4: output back-pressure bounds acceptance to the FIFO depth
        clear_stats();
        base0 = idx[0];
        out_rdy = 0; lim[0] = idx[0] + 64;
        repeat (12) @(negedge clk);
        #4;
        chk("t4_accepted", idx[0] - base0, 4);
        chk("t4_s0_rdy", s0_rdy, 0);
        chk("t4_out_vld", out_vld, 1);
        @(negedge clk); out_rdy = 1;
        wait_done(400);
        chk("t4_out_cnt", out_cnt, 64);

        // 5: granted s1 stalls; s0 must wait for the whole s1 block
        clear_stats();
        base1 = idx[1];
        lim[1] = idx[1] + 64; en[1] = 1;
        n = 0;
        while (idx[1] == base1 && n < 50) begin @(negedge clk); n++; end
        base0 = idx[0];
        lim[0] = idx[0] + 64;
        n = 0;
        while (idx[1] - base1 < 10 && n < 200) begin @(negedge clk); n++; end
        hold[1] = 1;
        repeat (20) @(negedge clk);
        chk("t5_s1_at_stall", idx[1] - base1, 10);
        chk("t5_s0_blocked", idx[0] - base0, 0);
        hold[1] = 0;
        wait_done(600);
        chk("t5_first_src", (blk_src_q.size() == 2) ? blk_src_q[0] : -1, 1);
        chk("t5_second_src", (blk_src_q.size() == 2) ? blk_src_q[1] : -1, 0);
        chk("t5_order", (blk_start_q.size() == 2 && blk_end_q.size() == 2) ? (blk_start_q[1] > blk_end_q[0]) : 0, 1);
        en[1] = 0;

        // 6: reset mid-block with FIFO occupied, then a spurious converter valid
        clear_stats();
        base0 = idx[0];
        out_rdy = 0; lim[0] = idx[0] + 64;
        n = 0;
        while (idx[0] - base0 < 4 && n < 50) begin @(negedge clk); n++; end
        repeat (2) @(negedge clk);
        rstn = 0;
        #4;
        chk("t6_rst_ctrl", {out_vld, s0_rdy, s1_rdy, cv_vld_i, blk_done, err, fsm_state}, 0);
        chk("t6_rst_data", {out_y, out_cb, out_cr, out_src, out_last, cv_r}, 0);
        exp_q.delete();
        idx[0] = ((idx[0] + 63) / 64) * 64;
        lim[0] = idx[0];
        @(negedge clk); rstn = 1; out_rdy = 1;
        @(negedge clk); #4;
        chk("t6_err_clear", err, 0);
        chk("t6_empty", out_vld, 0);
        @(negedge clk); spur = 1;
        @(negedge clk); spur = 0;
        #4;
        chk("t6_err_set", err, 1);
        repeat (5) @(negedge clk);
        #4;
        chk("t6_err_sticky", err, 1);
        chk("t6_no_push", out_vld, 0);
        @(negedge clk); rstn = 0;
        #4;
        chk("t6_err_reset", err, 0);
        @(negedge clk); rstn = 1;
        repeat (2) @(negedge clk);

        chk("final_queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
